// File: rtl/voice_scheduler.sv
// Two-voice key allocator: scans the synchronized key vector one index per clock,
// assigning presses to a free voice (or stealing the oldest) and freeing voices on release.
module voice_scheduler #(
    parameter int NKEYS = 48,
    parameter int IDXW  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] key,
    input  logic             scan_en,
    output logic [IDXW-1:0]  voice_key0,
    output logic [IDXW-1:0]  voice_key1,
    output logic [1:0]       voice_active,
    output logic             evt_valid,
    output logic             evt_on,
    output logic             evt_voice,
    output logic [IDXW-1:0]  evt_key,
    output logic             evt_steal
);

    localparam logic [IDXW-1:0] KEY_NONE = IDXW'(NKEYS);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NKEYS - 1);

    logic [NKEYS-1:0] key_m, key_s;
    logic [IDXW-1:0]  idx;
    logic             oldest;

    logic             cur, hold0, hold1, v;
    logic [IDXW-1:0]  nxt_vk0, nxt_vk1;
    logic [1:0]       nxt_act;
    logic             nxt_oldest;
    logic             ev, ev_on, ev_voice, ev_steal;
    logic [IDXW-1:0]  ev_key;

    assign cur   = key_s[idx];
    assign hold0 = voice_active[0] && (voice_key0 == idx);
    assign hold1 = voice_active[1] && (voice_key1 == idx);

    // Release has priority over a new press; a held key produces no event.
    always_comb begin
        nxt_vk0    = voice_key0;
        nxt_vk1    = voice_key1;
        nxt_act    = voice_active;
        nxt_oldest = oldest;
        ev         = 1'b0;
        ev_on      = evt_on;
        ev_voice   = evt_voice;
        ev_key     = evt_key;
        ev_steal   = evt_steal;
        v          = 1'b0;
        if (scan_en) begin
            if (!cur && (hold0 || hold1)) begin
                v        = hold1;
                ev       = 1'b1;
                ev_on    = 1'b0;
                ev_voice = v;
                ev_key   = idx;
                ev_steal = 1'b0;
                nxt_act[v] = 1'b0;
                if (v) nxt_vk1 = KEY_NONE;
                else   nxt_vk0 = KEY_NONE;
                if (voice_active[~v]) nxt_oldest = ~v;
            end else if (cur && !hold0 && !hold1) begin
                if (!voice_active[0]) begin
                    v        = 1'b0;
                    ev_steal = 1'b0;
                end else if (!voice_active[1]) begin
                    v        = 1'b1;
                    ev_steal = 1'b0;
                end else begin
                    v        = oldest;
                    ev_steal = 1'b1;
                end
                ev         = 1'b1;
                ev_on      = 1'b1;
                ev_voice   = v;
                ev_key     = idx;
                nxt_act[v] = 1'b1;
                nxt_oldest = ~v;
                if (v) nxt_vk1 = idx;
                else   nxt_vk0 = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_m        <= '0;
            key_s        <= '0;
            idx          <= '0;
            oldest       <= 1'b0;
            voice_key0   <= KEY_NONE;
            voice_key1   <= KEY_NONE;
            voice_active <= 2'b00;
            evt_valid    <= 1'b0;
            evt_on       <= 1'b0;
            evt_voice    <= 1'b0;
            evt_key      <= KEY_NONE;
            evt_steal    <= 1'b0;
        end else begin
            key_m        <= key;
            key_s        <= key_m;
            if (scan_en) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            oldest       <= nxt_oldest;
            voice_key0   <= nxt_vk0;
            voice_key1   <= nxt_vk1;
            voice_active <= nxt_act;
            evt_valid    <= ev;
            evt_on       <= ev_on;
            evt_voice    <= ev_voice;
            evt_key      <= ev_key;
            evt_steal    <= ev_steal;
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: a press-order reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized key/enable/reset phase.
module tb_voice_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] key = '0;
    logic        scan_en = 1'b1;
    logic [5:0]  voice_key0, voice_key1, evt_key;
    logic [1:0]  voice_active;
    logic        evt_valid, evt_on, evt_voice, evt_steal;

    voice_scheduler dut (
        .clk(clk), .rst(rst), .key(key), .scan_en(scan_en),
        .voice_key0(voice_key0), .voice_key1(voice_key1), .voice_active(voice_active),
        .evt_valid(evt_valid), .evt_on(evt_on), .evt_voice(evt_voice),
        .evt_key(evt_key), .evt_steal(evt_steal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit got;
    int nev;

    // Reference: each voice remembers when it was allocated; the steal victim is the earlier one.
    logic [47:0] m_ks1, m_ks2;
    int m_idx, m_tick;
    int m_vk[2];
    bit m_act[2];
    int m_t[2];
    int e_valid, e_on, e_voice, e_key, e_steal;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ks1 = '0; m_ks2 = '0; m_idx = 0; m_tick = 1;
        for (int i = 0; i < 2; i++) begin m_vk[i] = 48; m_act[i] = 0; m_t[i] = 0; end
        e_valid = 0; e_on = 0; e_voice = 0; e_key = 48; e_steal = 0;
    endtask

    task automatic m_update();
        int k, h, v;
        k = int'(m_ks2[m_idx]);
        h = -1;
        for (int i = 0; i < 2; i++) if (m_act[i] && m_vk[i] == m_idx) h = i;
        e_valid = 0;
        if (scan_en) begin
            if (k == 0 && h >= 0) begin
                e_valid = 1; e_on = 0; e_voice = h; e_key = m_idx; e_steal = 0;
                m_act[h] = 0; m_vk[h] = 48;
            end else if (k == 1 && h < 0) begin
                if (!m_act[0]) begin v = 0; e_steal = 0; end
                else if (!m_act[1]) begin v = 1; e_steal = 0; end
                else begin v = (m_t[0] < m_t[1]) ? 0 : 1; e_steal = 1; end
                e_valid = 1; e_on = 1; e_voice = v; e_key = m_idx;
                m_act[v] = 1; m_vk[v] = m_idx; m_t[v] = m_tick; m_tick++;
            end
            m_idx = (m_idx + 1) % 48;
        end
        m_ks2 = m_ks1;
        m_ks1 = key;
    endtask

    task automatic compare();
        chk("evt_valid", int'(evt_valid), e_valid);
        chk("voice_key0", int'(voice_key0), m_vk[0]);
        chk("voice_key1", int'(voice_key1), m_vk[1]);
        chk("voice_active", int'(voice_active), int'(m_act[1]) * 2 + int'(m_act[0]));
        if (e_valid == 1) begin
            chk("evt_on", int'(evt_on), e_on);
            chk("evt_voice", int'(evt_voice), e_voice);
            chk("evt_key", int'(evt_key), e_key);
            chk("evt_steal", int'(evt_steal), e_steal);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) m_reset();
        else m_update();
        #1;
        compare();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_evt(input int n, input string name);
        got = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (evt_valid) begin got = 1; break; end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s: no event within %0d cycles, expected one", name, n);
        end
    endtask

    task automatic count_evts(input int n);
        nev = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (evt_valid) nev++;
        end
    endtask

    initial begin
        m_reset();
        steps(3);
        rst = 1'b0;

        // Idle scanning
        count_evts(100);
        chk("idle_events", nev, 0);
        chk("idle_vk0", int'(voice_key0), 48);
        chk("idle_vk1", int'(voice_key1), 48);
        chk("idle_active", int'(voice_active), 0);

        // Single press
        key[9] = 1'b1;
        wait_evt(51, "on9");
        chk("on9_on", int'(evt_on), 1);
        chk("on9_voice", int'(evt_voice), 0);
        chk("on9_key", int'(evt_key), 9);
        chk("on9_vk0", int'(voice_key0), 9);
        chk("on9_active", int'(voice_active), 1);
        count_evts(200);
        chk("hold9_events", nev, 0);

        // Second voice then steal of the oldest
        key[21] = 1'b1;
        wait_evt(51, "on21");
        chk("on21_voice", int'(evt_voice), 1);
        key[30] = 1'b1;
        wait_evt(51, "steal30");
        chk("steal_voice", int'(evt_voice), 0);
        chk("steal_key", int'(evt_key), 30);
        chk("steal_flag", int'(evt_steal), 1);
        chk("steal_vk0", int'(voice_key0), 30);
        chk("steal_vk1", int'(voice_key1), 21);
        key = '0;
        steps(110);
        chk("settle1_active", int'(voice_active), 0);

        // Simultaneous presses, issued so both land in the same pass from index 0
        for (int i = 0; i < 48 && m_idx != 47; i++) step();
        key[5] = 1'b1;
        key[40] = 1'b1;
        wait_evt(51, "on5");
        chk("on5_key", int'(evt_key), 5);
        chk("on5_voice", int'(evt_voice), 0);
        wait_evt(48, "on40");
        chk("on40_key", int'(evt_key), 40);
        chk("on40_voice", int'(evt_voice), 1);
        key[5] = 1'b0;
        wait_evt(51, "off5");
        chk("off5_on", int'(evt_on), 0);
        chk("off5_voice", int'(evt_voice), 0);
        chk("off5_vk0", int'(voice_key0), 48);
        key = '0;
        steps(110);

        // Frozen scan
        scan_en = 1'b0;
        key[12] = 1'b1;
        count_evts(60);
        chk("frozen_events", nev, 0);
        chk("frozen_vk0", int'(voice_key0), 48);
        chk("frozen_active", int'(voice_active), 0);
        scan_en = 1'b1;
        wait_evt(49, "on12");
        chk("on12_key", int'(evt_key), 12);
        chk("on12_voice", int'(evt_voice), 0);
        key = '0;
        steps(110);

        // Asynchronous reset with both voices busy
        key[3] = 1'b1;
        key[7] = 1'b1;
        steps(110);
        chk("busy_active", int'(voice_active), 3);
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        chk("arst_active", int'(voice_active), 0);
        chk("arst_vk0", int'(voice_key0), 48);
        chk("arst_vk1", int'(voice_key1), 48);
        chk("arst_evt_valid", int'(evt_valid), 0);
        chk("arst_evt_key", int'(evt_key), 48);
        steps(2);
        rst = 1'b0;
        wait_evt(51, "realloc3");
        chk("realloc_key", int'(evt_key), 3);
        chk("realloc_voice", int'(evt_voice), 0);

        // Randomized keys, enable and occasional reset
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 14) == 0) begin
                int kk;
                kk = $urandom_range(0, 47);
                key[kk] = ~key[kk];
            end
            if ($urandom_range(0, 39) == 0) scan_en = ~scan_en;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 699) == 0) begin
                rst = 1'b1;
                m_reset();
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
